// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants for the CPU control path:
//   - 4-bit opcodes OP_NOP..OP_HLT (IR[7:4])
//   - T-state step constants T0..T4
//   - bit positions of the control word produced by microcode_rom
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Opcodes; 9..D are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // T-states.
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;

    // Control-word bit indices.
    localparam int CW_PC_EN    = 0;
    localparam int CW_PC_JMP   = 1;
    localparam int CW_PC_OUT   = 2;
    localparam int CW_MAR_IN   = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_RAM_IN   = 5;
    localparam int CW_IR_IN    = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_A_IN     = 8;
    localparam int CW_A_OUT    = 9;
    localparam int CW_B_IN     = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_FLAGS_IN = 13;
    localparam int CW_OUT_IN   = 14;
    localparam int CW_HLT      = 15;  // internal: request to enter HALT
    localparam int CW_WIDTH    = 16;

endpackage

// File: rtl/microcode_rom.sv
// ---------------------------------------------------------------------------
// microcode_rom
// Purely combinational decode of {opcode, step, c, z} into the control word.
// Ports:
//   opcode  in  4       IR[7:4]
//   step    in  STEP_W  current T-state
//   c, z    in  1       latched carry / zero flags
//   cw      out CW_WIDTH control word, bit positions CW_* from cpu_ctrl_pkg
// Every step asserts at most one bus driver (pc_out, ram_out, ir_out,
// a_out, alu_out). Steps beyond T4 decode to an all-zero word.
// ---------------------------------------------------------------------------
module microcode_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [3:0]          opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                c,
    input  logic                z,
    output logic [CW_WIDTH-1:0] cw
);

    always_comb begin
        cw = '0;
        case (step)
            STEP_W'(T0): begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            STEP_W'(T1): begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_IN]   = 1'b1;
                cw[CW_PC_EN]   = 1'b1;
            end
            STEP_W'(T2): begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_A_IN]   = 1'b1;
                    end
                    OP_JMP: cw[CW_PC_JMP] = 1'b1;
                    OP_JC:  cw[CW_PC_JMP] = c;
                    OP_JZ:  cw[CW_PC_JMP] = z;
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end
                    OP_HLT: cw[CW_HLT] = 1'b1;
                    default: ;
                endcase
            end
            STEP_W'(T3): begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                        cw[CW_ALU_SUB] = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_W'(T4): begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]  = 1'b1;
                    cw[CW_A_IN]     = 1'b1;
                    cw[CW_FLAGS_IN] = 1'b1;
                    cw[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Fetch/execute controller for the 4-bit-address, 8-bit-data CPU. Runs a
// fixed NSTEPS-long T-state ring per instruction and fans the microcode
// control word out to the PC, MAR, RAM, IR, A, B, ALU, flags and OUT strobes.
// Ports:
//   CLK, rst          clock; synchronous active-high reset
//   instr[7:0]        IR contents: [7:4] opcode, [3:0] operand
//   flag_c, flag_z    latched ALU flags (used by JC / JZ)
//   pc_en, pc_jmp,    PC count enable, load strobe and load value
//   pc_jmploc[3:0]
//   pc_out .. out_in  bus drive / load strobes
//   halted            high while in HALT
//   tstate            current step (debug view of the sequencer state)
// While rst is high every output is forced to 0. In HALT the step counter
// freezes at T2 and all strobes are 0 until rst.
// ---------------------------------------------------------------------------
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NSTEPS = 5,
    parameter int STEP_W = 3
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [7:0]        instr,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic              pc_en,
    output logic              pc_jmp,
    output logic [3:0]        pc_jmploc,
    output logic              pc_out,
    output logic              mar_in,
    output logic              ram_out,
    output logic              ram_in,
    output logic              ir_in,
    output logic              ir_out,
    output logic              a_in,
    output logic              a_out,
    output logic              b_in,
    output logic              alu_out,
    output logic              alu_sub,
    output logic              flags_in,
    output logic              out_in,
    output logic              halted,
    output logic [STEP_W-1:0] tstate
);

    logic [STEP_W-1:0]   step;
    logic                halt_q;
    logic [CW_WIDTH-1:0] cw;
    logic                active;

    microcode_rom #(.STEP_W(STEP_W)) u_rom (
        .opcode (instr[7:4]),
        .step   (step),
        .c      (flag_c),
        .z      (flag_z),
        .cw     (cw)
    );

    // Step ring and halt flag. HLT's T2 word freezes the ring in place, so
    // tstate keeps reading 2 for as long as the CPU is halted.
    always_ff @(posedge CLK) begin
        if (rst) begin
            step   <= '0;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            if (cw[CW_HLT]) begin
                halt_q <= 1'b1;
            end else if (step == STEP_W'(NSTEPS - 1)) begin
                step <= '0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    // Strobes are qualified combinationally so that asserting rst mid-
    // instruction kills them in the same cycle, not one edge later.
    assign active = !rst && !halt_q;

    assign pc_en     = active & cw[CW_PC_EN];
    assign pc_jmp    = active & cw[CW_PC_JMP];
    assign pc_out    = active & cw[CW_PC_OUT];
    assign mar_in    = active & cw[CW_MAR_IN];
    assign ram_out   = active & cw[CW_RAM_OUT];
    assign ram_in    = active & cw[CW_RAM_IN];
    assign ir_in     = active & cw[CW_IR_IN];
    assign ir_out    = active & cw[CW_IR_OUT];
    assign a_in      = active & cw[CW_A_IN];
    assign a_out     = active & cw[CW_A_OUT];
    assign b_in      = active & cw[CW_B_IN];
    assign alu_out   = active & cw[CW_ALU_OUT];
    assign alu_sub   = active & cw[CW_ALU_SUB];
    assign flags_in  = active & cw[CW_FLAGS_IN];
    assign out_in    = active & cw[CW_OUT_IN];

    assign pc_jmploc = rst ? 4'h0 : instr[3:0];
    assign halted    = !rst && halt_q;
    assign tstate    = rst ? '0 : step;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer: reset checks, a table of
// per-instruction strobe sequences, hand-written HALT and reset-mid-ADD
// sequences, and a randomized run against a reference model of the
// instruction set's step/strobe rules.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    // Bench-side encoding of the observable strobes (independent of the RTL).
    localparam logic [15:0] S_HALTED   = 16'h8000;
    localparam logic [15:0] S_PC_EN    = 16'h4000;
    localparam logic [15:0] S_PC_JMP   = 16'h2000;
    localparam logic [15:0] S_PC_OUT   = 16'h1000;
    localparam logic [15:0] S_MAR_IN   = 16'h0800;
    localparam logic [15:0] S_RAM_OUT  = 16'h0400;
    localparam logic [15:0] S_RAM_IN   = 16'h0200;
    localparam logic [15:0] S_IR_IN    = 16'h0100;
    localparam logic [15:0] S_IR_OUT   = 16'h0080;
    localparam logic [15:0] S_A_IN     = 16'h0040;
    localparam logic [15:0] S_A_OUT    = 16'h0020;
    localparam logic [15:0] S_B_IN     = 16'h0010;
    localparam logic [15:0] S_ALU_OUT  = 16'h0008;
    localparam logic [15:0] S_ALU_SUB  = 16'h0004;
    localparam logic [15:0] S_FLAGS_IN = 16'h0002;
    localparam logic [15:0] S_OUT_IN   = 16'h0001;

    localparam logic [15:0] FETCH0 = S_PC_OUT | S_MAR_IN;
    localparam logic [15:0] FETCH1 = S_RAM_OUT | S_IR_IN | S_PC_EN;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;
    logic       pc_en, pc_jmp, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halted;
    logic [3:0] pc_jmploc;
    logic [2:0] tstate;

    always #5 CLK = ~CLK;

    control_sequencer dut (
        .CLK       (CLK),
        .rst       (rst),
        .instr     (instr),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .pc_en     (pc_en),
        .pc_jmp    (pc_jmp),
        .pc_jmploc (pc_jmploc),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .ram_out   (ram_out),
        .ram_in    (ram_in),
        .ir_in     (ir_in),
        .ir_out    (ir_out),
        .a_in      (a_in),
        .a_out     (a_out),
        .b_in      (b_in),
        .alu_out   (alu_out),
        .alu_sub   (alu_sub),
        .flags_in  (flags_in),
        .out_in    (out_in),
        .halted    (halted),
        .tstate    (tstate)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] dut_word();
        return {halted, pc_en, pc_jmp, pc_out, mar_in, ram_out, ram_in, ir_in,
                ir_out, a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus-contention and PC-strobe invariants.
    task automatic check_invariants(input string name);
        int drivers;
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        check({name, " bus drivers<=1"}, 32'(drivers <= 1), 32'd1);
        check({name, " pc_en&pc_jmp"}, 32'(pc_en & pc_jmp), 32'd0);
    endtask

    // Reference model: strobes an instruction asserts in a given step.
    function automatic logic [15:0] model_strobes(input logic [3:0] op, input int step,
                                                  input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0;
        if (step == 0) w = FETCH0;
        else if (step == 1) w = FETCH1;
        else begin
            case (op)
                4'h1: if (step == 2) w = S_IR_OUT | S_MAR_IN;
                      else if (step == 3) w = S_RAM_OUT | S_A_IN;
                4'h2, 4'h3: begin
                    if (step == 2) w = S_IR_OUT | S_MAR_IN;
                    else if (step == 3) w = S_RAM_OUT | S_B_IN;
                    else w = S_ALU_OUT | S_A_IN | S_FLAGS_IN;
                    if (op == 4'h3 && step >= 3) w = w | S_ALU_SUB;
                end
                4'h4: if (step == 2) w = S_IR_OUT | S_MAR_IN;
                      else if (step == 3) w = S_A_OUT | S_RAM_IN;
                4'h5: if (step == 2) w = S_IR_OUT | S_A_IN;
                4'h6: if (step == 2) w = S_PC_JMP;
                4'h7: if (step == 2 && c) w = S_PC_JMP;
                4'h8: if (step == 2 && z) w = S_PC_JMP;
                4'hE: if (step == 2) w = S_A_OUT | S_OUT_IN;
                default: w = 16'h0;
            endcase
        end
        return w;
    endfunction

    // ---------------- drivers ----------------
    typedef struct packed {
        logic [7:0]       instr;
        logic             c;
        logic             z;
        logic [4:0][15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] i, input logic c, input logic z,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        vec_t v;
        v.instr  = i;
        v.c      = c;
        v.z      = z;
        v.exp[0] = FETCH0;
        v.exp[1] = FETCH1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        vecs.push_back(v);
    endtask

    // Hold rst for two cycles, checking that everything reads 0, then release
    // on a negedge so the next cycle is T0.
    task automatic do_reset(input string name);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            #1;
            check({name, " rst strobes"}, 32'(dut_word()), 32'd0);
            check({name, " rst tstate"}, 32'(tstate), 32'd0);
            check({name, " rst jmploc"}, 32'(pc_jmploc), 32'd0);
        end
        @(negedge CLK);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          m_step;
        logic        m_halted;
        logic [15:0] e;
        string       nm;

        // Table of single-instruction sequences T0..T4.
        add_vec(8'h1A, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_A_IN, 16'h0);
        add_vec(8'h25, 1'b1, 1'b1, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_B_IN,
                S_ALU_OUT | S_A_IN | S_FLAGS_IN);
        add_vec(8'h3F, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_B_IN | S_ALU_SUB,
                S_ALU_OUT | S_A_IN | S_FLAGS_IN | S_ALU_SUB);
        add_vec(8'h47, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_A_OUT | S_RAM_IN, 16'h0);
        add_vec(8'h59, 1'b0, 1'b0, S_IR_OUT | S_A_IN, 16'h0, 16'h0);
        add_vec(8'h63, 1'b0, 1'b0, S_PC_JMP, 16'h0, 16'h0);
        add_vec(8'h7C, 1'b1, 1'b0, S_PC_JMP, 16'h0, 16'h0);
        add_vec(8'h7C, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
        add_vec(8'h8D, 1'b0, 1'b1, S_PC_JMP, 16'h0, 16'h0);
        add_vec(8'h8D, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        add_vec(8'hE0, 1'b0, 1'b0, S_A_OUT | S_OUT_IN, 16'h0, 16'h0);
        add_vec(8'hB5, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
        add_vec(8'h00, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

        foreach (vecs[vi]) begin
            instr  = vecs[vi].instr;
            flag_c = vecs[vi].c;
            flag_z = vecs[vi].z;
            nm = $sformatf("vec%0d(%h)", vi, vecs[vi].instr);
            do_reset(nm);
            for (int s = 0; s < 5; s++) exp_q.push_back(vecs[vi].exp[s]);
            for (int s = 0; s < 5; s++) begin
                e = exp_q.pop_front();
                check($sformatf("%s T%0d strobes", nm, s), 32'(dut_word()), 32'(e));
                check($sformatf("%s T%0d tstate", nm, s), 32'(tstate), 32'(s));
                check($sformatf("%s T%0d jmploc", nm, s), 32'(pc_jmploc), 32'(vecs[vi].instr[3:0]));
                check_invariants(nm);
                @(negedge CLK);
                #1;
            end
            // Ring wraps back to the next fetch.
            check({nm, " wrap tstate"}, 32'(tstate), 32'd0);
            check({nm, " wrap strobes"}, 32'(dut_word()), 32'(FETCH0));
        end

        // HALT: no strobes in T2, then frozen at T2 with halted=1 until rst.
        instr = 8'hF0;
        do_reset("hlt");
        for (int s = 0; s < 3; s++) begin
            check($sformatf("hlt T%0d strobes", s), 32'(dut_word()),
                  32'((s == 0) ? FETCH0 : (s == 1) ? FETCH1 : 16'h0));
            @(negedge CLK);
            #1;
        end
        instr = 8'h1A;  // IR contents must not matter once halted
        for (int k = 0; k < 20; k++) begin
            check($sformatf("hlt hold%0d word", k), 32'(dut_word()), 32'(S_HALTED));
            check($sformatf("hlt hold%0d tstate", k), 32'(tstate), 32'd2);
            @(negedge CLK);
            #1;
        end
        do_reset("hlt exit");
        check("hlt exit tstate", 32'(tstate), 32'd0);
        check("hlt exit word", 32'(dut_word()), 32'(FETCH0));

        // Reset asserted during T3 of ADD: strobes die immediately, restart at T0.
        instr = 8'h25;
        do_reset("midrst");
        repeat (3) @(negedge CLK);
        #1;
        check("midrst at T3 tstate", 32'(tstate), 32'd3);
        rst = 1'b1;
        #1;
        check("midrst T3 killed", 32'(dut_word()), 32'd0);
        @(negedge CLK);
        #1;
        check("midrst held word", 32'(dut_word()), 32'd0);
        check("midrst held tstate", 32'(tstate), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst restart tstate", 32'(tstate), 32'd0);
        check("midrst restart word", 32'(dut_word()), 32'(FETCH0));

        // Randomized run against the model.
        do_reset("rnd");
        m_step   = 0;
        m_halted = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (m_halted) rst = ($urandom_range(0, 5) == 0);
            else          rst = ($urandom_range(0, 39) == 0);
            if (m_step == 0 && !m_halted) begin
                instr  = 8'($urandom_range(0, 255));
                flag_c = 1'($urandom_range(0, 1));
                flag_z = 1'($urandom_range(0, 1));
            end
            #1;
            if (rst)           e = 16'h0;
            else if (m_halted) e = S_HALTED;
            else               e = model_strobes(instr[7:4], m_step, flag_c, flag_z);
            exp_q.push_back(e);
            check($sformatf("rnd%0d strobes", cyc), 32'(dut_word()), 32'(exp_q.pop_front()));
            check($sformatf("rnd%0d tstate", cyc), 32'(tstate), rst ? 32'd0 : 32'(m_step));
            if (!rst) check($sformatf("rnd%0d jmploc", cyc), 32'(pc_jmploc), 32'(instr[3:0]));
            check_invariants($sformatf("rnd%0d", cyc));
            // Advance the model across the coming edge.
            if (rst) begin
                m_step   = 0;
                m_halted = 1'b0;
            end else if (!m_halted) begin
                if (instr[7:4] == 4'hF && m_step == 2) m_halted = 1'b1;
                else m_step = (m_step + 1) % 5;
            end
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
